// File: rtl/dil_field_sequencer.sv
// Field sequencer: walks the per-mode field list, tagging a zero-latency word stream with
// field id and last flags. Optional cycle counter enabled by DIL_SEQ_PERF_CNT_EN.
module dil_field_sequencer #(
  parameter int unsigned W             = 32,
  parameter int unsigned MSG_MAX_BYTES = 3300
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [2:0]   sec_level,
  input  logic [11:0]  msg_len,
  input  logic         abort,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [2:0]   m_field,
  output logic         m_field_last,
  output logic         m_frame_last,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  perf_cycles
);

  localparam int unsigned CW     = 11;
  localparam int unsigned Sh     = (W == 64) ? 6 : 5;
  localparam logic [16:0] WRound = 17'(W - 1);

  localparam logic [2:0] FSeed = 3'd0;
  localparam logic [2:0] FS1   = 3'd1;
  localparam logic [2:0] FS2   = 3'd2;
  localparam logic [2:0] FT0   = 3'd3;
  localparam logic [2:0] FT1   = 3'd4;
  localparam logic [2:0] FZ    = 3'd5;
  localparam logic [2:0] FH    = 3'd6;
  localparam logic [2:0] FMsg  = 3'd7;

  localparam logic [1:0] MdKeygen = 2'b00;
  localparam logic [1:0] MdSign   = 2'b10;
  localparam logic [1:0] MdVerify = 2'b01;

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  state_e        state_q, state_d;
  logic [1:0]    mode_q;
  logic [1:0]    lvl_q;
  logic [11:0]   len_q;
  logic [2:0]    step_q, step_d;
  logic [CW-1:0] word_q, word_d;
  logic          err_q, err_d;
  logic          accept;

  function automatic logic [16:0] pick(input logic [1:0] lv, input logic [16:0] a,
                                       input logic [16:0] b, input logic [16:0] c);
    return (lv == 2'd0) ? a : ((lv == 2'd1) ? b : c);
  endfunction

  function automatic logic [16:0] field_bits(input logic [2:0] f, input logic [1:0] lv,
                                             input logic [11:0] len);
    logic [16:0] bits;
    bits = 17'd256;
    case (f)
      FSeed:   bits = 17'd256;
      FS1:     bits = pick(lv, 17'd3072, 17'd5120, 17'd5376);
      FS2:     bits = pick(lv, 17'd3072, 17'd6144, 17'd6144);
      FT0:     bits = pick(lv, 17'd13312, 17'd19968, 17'd26624);
      FT1:     bits = pick(lv, 17'd10240, 17'd15360, 17'd20480);
      FZ:      bits = pick(lv, 17'd18432, 17'd25600, 17'd35840);
      FH:      bits = pick(lv, 17'd672, 17'd488, 17'd664);
      default: bits = {2'b00, len, 3'b000};
    endcase
    return bits;
  endfunction

  function automatic logic [2:0] seq_field(input logic [1:0] md, input logic [2:0] st);
    logic [2:0] f;
    f = FSeed;
    if (md == MdSign) begin
      case (st)
        3'd0:    f = FMsg;
        3'd4:    f = FS1;
        3'd5:    f = FS2;
        3'd6:    f = FT0;
        default: f = FSeed;
      endcase
    end else if (md == MdVerify) begin
      case (st)
        3'd1:    f = FT1;
        3'd3:    f = FZ;
        3'd4:    f = FH;
        3'd5:    f = FMsg;
        default: f = FSeed;
      endcase
    end
    return f;
  endfunction

  // Request decode
  logic       lvl_ok, mode_ok, len_ok, req_ok;
  logic [1:0] lvl_idx;
  logic [2:0] first_step;

  always_comb begin
    lvl_ok  = (sec_level == 3'd2) || (sec_level == 3'd3) || (sec_level == 3'd5);
    lvl_idx = (sec_level == 3'd2) ? 2'd0 : ((sec_level == 3'd3) ? 2'd1 : 2'd2);
    mode_ok = (mode != 2'b11);
    len_ok  = (32'(msg_len) <= MSG_MAX_BYTES);
    req_ok  = lvl_ok && mode_ok && len_ok;
    // Sign leads with MSG, so an empty message starts one step later.
    first_step = ((mode == MdSign) && (msg_len == 12'd0)) ? 3'd1 : 3'd0;
  end

  // Current field geometry
  logic [2:0]  cur_field;
  logic [16:0] cur_bits, cur_words;
  logic [2:0]  last_step;
  logic        field_last, frame_last, in_stream, xfer;

  always_comb begin
    cur_field  = seq_field(mode_q, step_q);
    cur_bits   = field_bits(cur_field, lvl_q, len_q);
    cur_words  = (cur_bits + WRound) >> Sh;
    field_last = ({{(17 - CW){1'b0}}, word_q} == (cur_words - 17'd1));
    case (mode_q)
      MdKeygen: last_step = 3'd0;
      MdSign:   last_step = 3'd6;
      default:  last_step = (len_q == 12'd0) ? 3'd4 : 3'd5;
    endcase
    frame_last = field_last && (step_q == last_step);
    in_stream  = (state_q == StStream);
    xfer       = in_stream && s_valid && m_ready;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    word_d  = word_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    if (abort) begin
      state_d = StIdle;
      step_d  = 3'd0;
      word_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (req_ok) begin
              accept  = 1'b1;
              state_d = StLoad;
              step_d  = first_step;
              word_d  = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StLoad: state_d = StStream;
        StStream: begin
          if (xfer) begin
            if (frame_last) begin
              state_d = StDone;
              word_d  = '0;
            end else if (field_last) begin
              step_d = step_q + 3'd1;
              word_d = '0;
            end else begin
              word_d = word_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = StIdle;
          step_d  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= 3'd0;
      word_q  <= '0;
      err_q   <= 1'b0;
      mode_q  <= 2'b00;
      lvl_q   <= 2'd0;
      len_q   <= 12'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      word_q  <= word_d;
      err_q   <= err_d;
      if (accept) begin
        mode_q <= mode;
        lvl_q  <= lvl_idx;
        len_q  <= msg_len;
      end
    end
  end

  always_comb begin
    m_data       = s_data;
    m_valid      = in_stream && s_valid;
    s_ready      = in_stream && m_ready;
    m_field      = in_stream ? cur_field : 3'd0;
    m_field_last = in_stream && field_last;
    m_frame_last = in_stream && frame_last;
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    err          = err_q;
  end

`ifdef DIL_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  // The accepting cycle counts as the first frame cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= 32'd0;
    end else if (accept) begin
      perf_q <= 32'd1;
    end else if (busy) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_dil_field_sequencer.sv
// Scoreboard bench for dil_field_sequencer: W=32 and W=64 instances, expected words queued
// per frame from fixed field tables and popped on each downstream transfer.
module tb_dil_field_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start64;
  logic [1:0]  mode;
  logic [2:0]  lvl;
  logic [11:0] len;
  logic        abort;
  logic        s_valid, m_ready;
  logic [63:0] sd;

  logic        sr32, mv32, fl32, frl32, busy32, done32, err32;
  logic [31:0] md32, perf32;
  logic [2:0]  fld32;
  logic        sr64, mv64, fl64, frl64, busy64, done64, err64;
  logic [63:0] md64;
  logic [31:0] perf64;
  logic [2:0]  fld64;

  always #5 clk = ~clk;

  dil_field_sequencer #(.W(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .mode(mode), .sec_level(lvl), .msg_len(len),
    .abort(abort), .s_data(sd[31:0]), .s_valid(s_valid), .s_ready(sr32), .m_data(md32),
    .m_valid(mv32), .m_ready(m_ready), .m_field(fld32), .m_field_last(fl32),
    .m_frame_last(frl32), .busy(busy32), .done(done32), .err(err32), .perf_cycles(perf32)
  );

  dil_field_sequencer #(.W(64)) u_dut64 (
    .clk(clk), .rst(rst), .start(start64), .mode(mode), .sec_level(lvl), .msg_len(len),
    .abort(abort), .s_data(sd), .s_valid(s_valid), .s_ready(sr64), .m_data(md64),
    .m_valid(mv64), .m_ready(m_ready), .m_field(fld64), .m_field_last(fl64),
    .m_frame_last(frl64), .busy(busy64), .done(done64), .err(err64), .perf_cycles(perf64)
  );

  logic        sel;
  logic        o_sr, o_mv, o_fl, o_frl, o_busy, o_done, o_err;
  logic [63:0] o_data;
  logic [2:0]  o_fld;
  assign o_sr   = sel ? sr64 : sr32;
  assign o_mv   = sel ? mv64 : mv32;
  assign o_fl   = sel ? fl64 : fl32;
  assign o_frl  = sel ? frl64 : frl32;
  assign o_busy = sel ? busy64 : busy32;
  assign o_done = sel ? done64 : done32;
  assign o_err  = sel ? err64 : err32;
  assign o_data = sel ? md64 : {32'h0, md32};
  assign o_fld  = sel ? fld64 : fld32;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  fld;
    logic        fl;
    logic        frl;
  } exp_t;

  exp_t sb[$];
  int   exp_f[8];
  int   exp_n[8];
  int   nfld;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] word_of(input logic s, input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return s ? {kk ^ 32'h0F0F_0000, ~kk} : {32'h0, kk ^ 32'hA5A5_0000};
  endfunction

  task automatic run_frame(input logic s, input logic [1:0] md, input logic [2:0] lv,
                           input logic [11:0] ln, input bit rnd, input int abort_at,
                           input int poke_at);
    exp_t e;
    int   k, sent, cyc;
    bit   xf, aborted;
    sel = s;
    sb.delete();
    k = 0;
    for (int i = 0; i < nfld; i++) begin
      for (int j = 0; j < exp_n[i]; j++) begin
        e.data = word_of(s, k);
        e.fld  = 3'(exp_f[i]);
        e.fl   = (j == exp_n[i] - 1);
        e.frl  = e.fl && (i == nfld - 1);
        sb.push_back(e);
        k++;
      end
    end
    @(posedge clk); #1;
    mode = md; lvl = lv; len = ln; m_ready = 1'b1; s_valid = 1'b1;
    sent = 0; sd = word_of(s, 0);
    if (s) start64 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; start64 = 1'b0;
    @(negedge clk);
    check("load_busy", o_busy, 1);
    check("load_s_ready", o_sr, 0);
    check("load_m_valid", o_mv, 0);
    @(posedge clk); #1;
    m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0; aborted = 0;
    while (sb.size() > 0 && !aborted && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      check("s_ready", o_sr, m_ready);
      check("m_valid", o_mv, s_valid);
      xf = o_mv && m_ready;
      if (xf) begin
        e = sb.pop_front();
        check("data", o_data, e.data);
        check("field", o_fld, e.fld);
        check("field_last", o_fl, e.fl);
        check("frame_last", o_frl, e.frl);
      end
      @(posedge clk); #1;
      start32 = 1'b0; start64 = 1'b0;
      if (abort) begin
        abort = 1'b0;
        aborted = 1;
      end
      if (xf) begin
        sent++;
        sd = word_of(s, sent);
      end
      if (!aborted) begin
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (sent == abort_at) abort = 1'b1;
        if (xf && sent == poke_at) begin
          if (s) start64 = 1'b1; else start32 = 1'b1;
        end
      end
    end
    if (aborted) begin
      @(negedge clk);
      check("abort_busy", o_busy, 0);
      check("abort_done", o_done, 0);
      check("abort_m_valid", o_mv, 0);
      check("abort_s_ready", o_sr, 0);
      s_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_no_done", o_done, 0);
    end else if (sb.size() > 0) begin
      check("timeout_words_left", 64'(sb.size()), 0);
      s_valid = 1'b0;
    end else begin
      s_valid = 1'b0;
      @(negedge clk);
      check("done_pulse", o_done, 1);
      check("done_busy", o_busy, 1);
      check("done_m_valid", o_mv, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_clear", o_done, 0);
      check("idle_busy", o_busy, 0);
    end
  endtask

  task automatic illegal_start(input string tag, input logic [1:0] md, input logic [2:0] lv,
                               input logic [11:0] ln);
    sel = 1'b0;
    @(posedge clk); #1;
    mode = md; lvl = lv; len = ln; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    @(negedge clk);
    check({tag, "_err"}, o_err, 1);
    check({tag, "_busy"}, o_busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_err_clear"}, o_err, 0);
    check({tag, "_still_idle"}, o_busy, 0);
  endtask

  task automatic set_keygen2_w32();
    exp_f = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_n = '{8, 0, 0, 0, 0, 0, 0, 0};
    nfld  = 1;
  endtask

  task automatic set_verify3_msg5_w32();
    exp_f = '{0, 4, 0, 5, 6, 7, 0, 0};
    exp_n = '{8, 480, 8, 800, 16, 2, 0, 0};
    nfld  = 6;
  endtask

  logic [31:0] perf_exp;

  initial begin
    rst = 1'b1; start32 = 0; start64 = 0; mode = 0; lvl = 0; len = 0; abort = 0;
    s_valid = 0; m_ready = 0; sd = '0; sel = 0;
`ifdef DIL_SEQ_PERF_CNT_EN
    perf_exp = 32'd11;
`else
    perf_exp = 32'd0;
`endif
    #12;
    check("rst_busy", busy32, 0);
    check("rst_done", done32, 0);
    check("rst_err", err32, 0);
    check("rst_m_valid", mv32, 0);
    check("rst_s_ready", sr32, 0);
    check("rst_field", fld32, 0);
    check("rst_field_last", fl32, 0);
    check("rst_frame_last", frl32, 0);
    check("rst_perf", perf32, 0);
    check("rst_busy64", busy64, 0);
    @(posedge clk); #1 rst = 1'b0;

    set_keygen2_w32();
    run_frame(1'b0, 2'b00, 3'd2, 12'd0, 0, -1, -1);
    check("perf_keygen2", perf32, perf_exp);

    illegal_start("lvl4", 2'b00, 3'd4, 12'd0);
    illegal_start("mode3", 2'b11, 3'd2, 12'd0);
    illegal_start("len3301", 2'b10, 3'd2, 12'd3301);

    // Verify, level 3, 5-byte message; a start pulse mid-frame must be ignored.
    set_verify3_msg5_w32();
    run_frame(1'b0, 2'b01, 3'd3, 12'd5, 0, -1, 100);

    // W=64 sign, level 5, empty message: MSG skipped, T0 ends the frame.
    exp_f = '{0, 0, 0, 1, 2, 3, 0, 0};
    exp_n = '{4, 4, 4, 84, 96, 416, 0, 0};
    nfld  = 6;
    run_frame(1'b1, 2'b10, 3'd5, 12'd0, 0, -1, -1);

    // W=64 verify, level 2, empty message: H (10.5 words rounded up) ends the frame.
    exp_f = '{0, 4, 0, 5, 6, 0, 0, 0};
    exp_n = '{4, 160, 4, 288, 11, 0, 0, 0};
    nfld  = 5;
    run_frame(1'b1, 2'b01, 3'd2, 12'd0, 0, -1, -1);

    // Sign, level 2, maximum message under random back-pressure.
    exp_f = '{7, 0, 0, 0, 1, 2, 3, 0};
    exp_n = '{825, 8, 8, 8, 96, 96, 416, 0};
    nfld  = 7;
    run_frame(1'b0, 2'b10, 3'd2, 12'd3300, 1, -1, -1);

    // Abort in the middle of Z.
    set_verify3_msg5_w32();
    run_frame(1'b0, 2'b01, 3'd3, 12'd5, 0, 896, -1);

    // Reset mid-frame, then a fresh frame must run normally.
    sel = 1'b0;
    @(posedge clk); #1;
    mode = 2'b01; lvl = 3'd3; len = 12'd5; s_valid = 1'b1; m_ready = 1'b1; start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", busy32, 0);
    check("midrst_m_valid", mv32, 0);
    check("midrst_s_ready", sr32, 0);
    check("midrst_perf", perf32, 0);
    @(posedge clk); #1 rst = 1'b0; s_valid = 1'b0;
    set_keygen2_w32();
    run_frame(1'b0, 2'b00, 3'd2, 12'd0, 0, -1, -1);
    check("perf_after_rst", perf32, perf_exp);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dil_field_sequencer.md
DIL_FIELD_SEQUENCER -- requirements
Module: dil_field_sequencer

Interface
REQ-001 Parameter W, default 32; word width in bits, legal values 32 and 64.
REQ-002 Parameter MSG_MAX_BYTES, default 3300; largest legal message length in bytes.
REQ-003 clk  input  1  single clock; all logic rises on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  frame request; sampled only in IDLE.
REQ-006 mode  input  2  00 keygen, 10 sign, 01 verify; 11 illegal.
REQ-007 sec_level  input  3  2, 3 or 5; any other value illegal.
REQ-008 msg_len  input  12  message length in bytes; sampled with start.
REQ-009 abort  input  1  synchronous frame abort.
REQ-010 s_data / s_valid / s_ready  in / in / out  W / 1 / 1  upstream word stream.
REQ-011 m_data / m_valid / m_ready  out / out / in  W / 1 / 1  downstream word stream.
REQ-012 m_field  output  3  field id: 0 SEED, 1 S1, 2 S2, 3 T0, 4 T1, 5 Z, 6 H, 7 MSG.
REQ-013 m_field_last / m_frame_last  output  1 / 1  last word of the current field / of the frame.
REQ-014 busy, done, err  output  1 each  frame active; 1-cycle completion pulse; 1-cycle rejection pulse.
REQ-015 perf_cycles  output  32  frame cycle count (see Configuration).

Function
REQ-016 Field bit sizes SHALL be (level 2/3/5): SEED 256/256/256; S1 3072/5120/5376; S2 3072/6144/6144; T0 13312/19968/26624; T1 10240/15360/20480; Z 18432/25600/35840; H 672/488/664.
REQ-017 Word count per field SHALL be ceil(bits/W); MSG word count SHALL be ceil(msg_len*8/W); the counter SHALL be wide enough for Z at W=32 (1120 words).
REQ-018 Field order SHALL be: keygen SEED; sign MSG, SEED(rho), SEED(K), SEED(tr), S1, S2, T0; verify SEED(rho), T1, SEED(c), Z, H, MSG.
REQ-019 MSG SHALL be skipped when msg_len is 0; the preceding field then carries m_frame_last.
REQ-020 States: IDLE -> LOAD on a legal start; LOAD -> STREAM after exactly 1 cycle; STREAM -> DONE on a transfer with m_frame_last; DONE -> IDLE after 1 cycle.
REQ-021 Start with illegal mode, illegal sec_level, or msg_len > MSG_MAX_BYTES SHALL pulse err for 1 cycle; the block SHALL stay in IDLE.
REQ-022 Start outside IDLE SHALL be ignored.
REQ-023 In STREAM: m_data = s_data, m_valid = s_valid, s_ready = m_ready, all combinational; zero latency.
REQ-024 s_ready and m_valid SHALL be 0 outside STREAM.
REQ-025 A transfer occurs when m_valid and m_ready are both 1; the word and field counters SHALL advance only on a transfer.
REQ-026 On the last word of a field, m_field_last SHALL be 1; the next transfer SHALL carry the next field id with the word count restarted.
REQ-027 busy SHALL be 1 in LOAD, STREAM and DONE; done SHALL pulse in DONE.
REQ-028 abort SHALL return the block to IDLE on the next edge from any state, without a done pulse; abort has priority over a coincident transfer.

Reset
REQ-029 rst SHALL force IDLE and clear all counters; busy, done, err, m_valid, s_ready, m_field_last, m_frame_last, m_field and perf_cycles SHALL be 0.
REQ-030 rst asserted mid-frame SHALL discard the frame; after release the block SHALL accept a new start.

Configuration
REQ-031 Macro DIL_SEQ_PERF_CNT_EN, when defined: perf_cycles clears on start acceptance, increments every cycle while busy, and holds its value in IDLE until the next accepted start.
REQ-032 Without DIL_SEQ_PERF_CNT_EN, perf_cycles SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-033 W=32, keygen, level 2, m_ready held 1 -> 8 SEED words; m_frame_last on word 8; done pulse in the cycle after that transfer.
REQ-034 W=32, verify, level 3, msg_len=5 -> field word counts 8, 480, 8, 800, 16, 2; m_field_last on each field's final word.
REQ-035 W=64, sign, level 5, msg_len=0 -> MSG skipped; counts 4, 4, 4, 84, 96, 416; m_frame_last on the last T0 word.
REQ-036 Random m_ready back-pressure, sign, level 2, msg_len=3300 -> 825 MSG words with none lost or duplicated; s_ready equals m_ready throughout.
REQ-037 start with sec_level=4 -> err 1-cycle pulse, busy stays 0; abort mid-Z -> IDLE next cycle, no done.
REQ-038 With DIL_SEQ_PERF_CNT_EN, keygen level 2, no stalls -> perf_cycles = 11; without the macro -> 0.
